// File: rtl/dqn_cu_param_if.sv
// Control/status bundle for dqn_cu_param: start/hold/st1 in, phase, step and episode counters plus event pulses out.
// With DQN_CU_GOALCNT_EN defined the bundle also carries goal_count.
interface dqn_cu_param_if #(
  parameter int CTRL_W  = 4,
  parameter int STEP_W  = 4,
  parameter int EP_W    = 12,
  parameter int STATE_W = 4
);
  logic               start;
  logic               hold;
  logic [STATE_W-1:0] st1;
  logic [CTRL_W-1:0]  controller;
  logic [STEP_W-1:0]  step;
  logic [EP_W-1:0]    episode;
  logic               step_tick;
  logic               episode_end;
  logic               goal_hit;
  logic               busy;
  logic               done;
`ifdef DQN_CU_GOALCNT_EN
  logic [EP_W-1:0]    goal_count;

  modport master (
    output start, hold, st1,
    input  controller, step, episode, step_tick, episode_end, goal_hit, busy, done, goal_count
  );
  modport slave (
    input  start, hold, st1,
    output controller, step, episode, step_tick, episode_end, goal_hit, busy, done, goal_count
  );
`else
  modport master (
    output start, hold, st1,
    input  controller, step, episode, step_tick, episode_end, goal_hit, busy, done
  );
  modport slave (
    input  start, hold, st1,
    output controller, step, episode, step_tick, episode_end, goal_hit, busy, done
  );
`endif
endinterface

// File: rtl/dqn_cu_param.sv
// DQN training control unit: sequences phase, step-in-episode and episode counters; halts in DONE after MAX_EP episodes.
// Optional DQN_CU_GOALCNT_EN adds a goal_count output counting goal-terminated episodes.
module dqn_cu_param #(
  parameter int PHASES     = 10,
  parameter int CTRL_W     = 4,
  parameter int STEP_W     = 4,
  parameter int MAX_STEP   = 15,
  parameter int EP_W       = 12,
  parameter int MAX_EP     = 4095,
  parameter int STATE_W    = 4,
  parameter int GOAL_STATE = 9
) (
  input logic           clk,
  input logic           rst,
  dqn_cu_param_if.slave bus
);

  localparam logic [CTRL_W-1:0]  LP_PHASES  = CTRL_W'(PHASES);
  localparam logic [STEP_W-1:0]  LP_MAXSTEP = STEP_W'(MAX_STEP);
  localparam logic [EP_W-1:0]    LP_LASTEP  = EP_W'(MAX_EP - 1);
  localparam logic [EP_W-1:0]    LP_MAXEP   = EP_W'(MAX_EP);
  localparam logic [STATE_W-1:0] LP_GOAL    = STATE_W'(GOAL_STATE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state,    w_state;
  logic [CTRL_W-1:0] r_ctrl,     w_ctrl;
  logic [STEP_W-1:0] r_step,     w_step;
  logic [EP_W-1:0]   r_ep,       w_ep;
  logic              r_tick,     w_tick;
  logic              r_ep_end,   w_ep_end;
  logic              r_goal_hit, w_goal_hit;
`ifdef DQN_CU_GOALCNT_EN
  logic [EP_W-1:0]   r_gc,       w_gc;
`endif

  logic w_goal;
  assign w_goal = (bus.st1 == LP_GOAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ctrl     <= '0;
      r_step     <= '0;
      r_ep       <= '0;
      r_tick     <= 1'b0;
      r_ep_end   <= 1'b0;
      r_goal_hit <= 1'b0;
`ifdef DQN_CU_GOALCNT_EN
      r_gc       <= '0;
`endif
    end else begin
      r_state    <= w_state;
      r_ctrl     <= w_ctrl;
      r_step     <= w_step;
      r_ep       <= w_ep;
      r_tick     <= w_tick;
      r_ep_end   <= w_ep_end;
      r_goal_hit <= w_goal_hit;
`ifdef DQN_CU_GOALCNT_EN
      r_gc       <= w_gc;
`endif
    end
  end

  always_comb begin
    w_state    = r_state;
    w_ctrl     = r_ctrl;
    w_step     = r_step;
    w_ep       = r_ep;
    w_tick     = 1'b0;
    w_ep_end   = 1'b0;
    w_goal_hit = 1'b0;
`ifdef DQN_CU_GOALCNT_EN
    w_gc       = r_gc;
`endif
    case (r_state)
      S_IDLE: begin
        w_ctrl = '0;
        if (bus.start) begin
          w_state = S_RUN;
          w_ctrl  = CTRL_W'(1);
        end
      end
      S_RUN: begin
        if (!bus.hold) begin
          if (r_ctrl != LP_PHASES) begin
            w_ctrl = r_ctrl + 1'b1;
          end else begin
            w_ctrl = CTRL_W'(1);
            w_tick = 1'b1;
            if ((r_step == LP_MAXSTEP) || w_goal) begin
              w_step     = '0;
              w_ep       = r_ep + 1'b1;
              w_ep_end   = 1'b1;
              w_goal_hit = w_goal;
`ifdef DQN_CU_GOALCNT_EN
              if (w_goal) w_gc = r_gc + 1'b1;
`endif
              // Final episode: pulses still fire on this edge, counters park in DONE.
              if (r_ep == LP_LASTEP) begin
                w_ep    = LP_MAXEP;
                w_state = S_DONE;
                w_ctrl  = '0;
              end
            end else begin
              w_step = r_step + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        w_state = S_DONE;
      end
      default: begin
        w_state = S_IDLE;
        w_ctrl  = '0;
      end
    endcase
  end

  assign bus.controller  = r_ctrl;
  assign bus.step        = r_step;
  assign bus.episode     = r_ep;
  assign bus.step_tick   = r_tick;
  assign bus.episode_end = r_ep_end;
  assign bus.goal_hit    = r_goal_hit;
  assign bus.busy        = (r_state == S_RUN);
  assign bus.done        = (r_state == S_DONE);
`ifdef DQN_CU_GOALCNT_EN
  assign bus.goal_count  = r_gc;
`endif

endmodule

// File: tb/tb_dqn_cu_param.sv
// Testbench for dqn_cu_param: directed scenarios plus randomized stimulus, every cycle compared to a
// cycle-count-based reference model (MAX_EP reduced to 3 so DONE is reachable).
module tb_dqn_cu_param;

  localparam int PHASES   = 10;
  localparam int CTRL_W   = 4;
  localparam int STEP_W   = 4;
  localparam int MAX_STEP = 15;
  localparam int EP_W     = 12;
  localparam int MAX_EP   = 3;
  localparam int STATE_W  = 4;
  localparam int GOAL     = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dqn_cu_param_if #(.CTRL_W(CTRL_W), .STEP_W(STEP_W), .EP_W(EP_W), .STATE_W(STATE_W)) u_if ();

  dqn_cu_param #(
    .PHASES(PHASES), .CTRL_W(CTRL_W), .STEP_W(STEP_W), .MAX_STEP(MAX_STEP),
    .EP_W(EP_W), .MAX_EP(MAX_EP), .STATE_W(STATE_W), .GOAL_STATE(GOAL)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if.slave)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=run 2=done; phase derived from unheld cycles since start.
  int          m_mode = 0;
  int unsigned m_cnt  = 0;
  int unsigned m_step = 0;
  int unsigned m_ep   = 0;
  int unsigned m_gc   = 0;
  bit          m_tick = 0, m_eend = 0, m_ghit = 0;

  task automatic model_step();
    bit ends, goal;
    m_tick = 0; m_eend = 0; m_ghit = 0;
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_step = 0; m_ep = 0; m_gc = 0;
    end else if (m_mode == 0) begin
      if (u_if.start) begin
        m_mode = 1;
        m_cnt  = 0;
      end
    end else if (m_mode == 1 && !u_if.hold) begin
      m_cnt++;
      if (m_cnt % PHASES == 0) begin
        m_tick = 1;
        goal = (int'(u_if.st1) == GOAL);
        ends = goal || (m_step == MAX_STEP);
        if (ends) begin
          m_eend = 1;
          m_ghit = goal;
          if (goal) m_gc++;
          m_step = 0;
          m_ep++;
          if (m_ep == MAX_EP) m_mode = 2;
        end else begin
          m_step++;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("controller", 32'(u_if.controller), (m_mode == 1) ? (m_cnt % PHASES) + 1 : 0);
    chk("step",       32'(u_if.step),        m_step);
    chk("episode",    32'(u_if.episode),     m_ep);
    chk("step_tick",  32'(u_if.step_tick),   32'(m_tick));
    chk("ep_end",     32'(u_if.episode_end), 32'(m_eend));
    chk("goal_hit",   32'(u_if.goal_hit),    32'(m_ghit));
    chk("busy",       32'(u_if.busy),        32'(m_mode == 1));
    chk("done",       32'(u_if.done),        32'(m_mode == 2));
`ifdef DQN_CU_GOALCNT_EN
    chk("goal_count", 32'(u_if.goal_count),  m_gc);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; u_if.start = 1'b0; u_if.hold = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  task automatic do_start();
    u_if.start = 1'b1;
    cycle();
    u_if.start = 1'b0;
  endtask

  initial begin
    u_if.start = 1'b0;
    u_if.hold  = 1'b0;
    u_if.st1   = '0;

    // Reset / idle
    do_reset();
    for (int i = 0; i < 20; i++) cycle();
    chk("idle_ctrl", 32'(u_if.controller), 0);

    // Timeout episode: boundary at E+160 ends episode without goal
    u_if.st1 = STATE_W'(1);
    do_start();
    for (int i = 0; i < 160; i++) cycle();
    chk("to_ep",    32'(u_if.episode), 1);
    chk("to_eend",  32'(u_if.episode_end), 1);
    chk("to_ghit",  32'(u_if.goal_hit), 0);
    chk("to_step",  32'(u_if.step), 0);

    // Goal episode: goal seen once step==3, boundary at E+40
    do_reset();
    u_if.st1 = STATE_W'(1);
    do_start();
    for (int i = 0; i < 40; i++) begin
      u_if.st1 = (m_step >= 3) ? STATE_W'(GOAL) : STATE_W'(1);
      cycle();
    end
    chk("goal_ghit", 32'(u_if.goal_hit), 1);
    chk("goal_ep",   32'(u_if.episode), 1);

    // Hold 7 cycles at controller==5: boundary moves to E+17
    do_reset();
    u_if.st1 = STATE_W'(1);
    do_start();
    for (int i = 0; i < 4; i++) cycle();
    chk("hold_pre", 32'(u_if.controller), 5);
    u_if.hold = 1'b1;
    for (int i = 0; i < 7; i++) cycle();
    chk("hold_ctrl", 32'(u_if.controller), 5);
    u_if.hold = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("hold_notick", 32'(u_if.step_tick), 0);
    cycle();
    chk("hold_tick", 32'(u_if.step_tick), 1);

    // Completion: goal from the start, DONE after E+30, start then ignored
    do_reset();
    u_if.st1 = STATE_W'(GOAL);
    do_start();
    for (int i = 0; i < 30; i++) cycle();
    chk("cmp_done", 32'(u_if.done), 1);
    chk("cmp_ep",   32'(u_if.episode), 3);
    u_if.start = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    u_if.start = 1'b0;
    chk("cmp_sticky", 32'(u_if.done), 1);

    // Reset during step 7, controller 4
    do_reset();
    u_if.st1 = STATE_W'(1);
    do_start();
    for (int i = 0; i < 73; i++) cycle();
    chk("mid_step", 32'(u_if.step), 7);
    chk("mid_ctrl", 32'(u_if.controller), 4);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(u_if.busy), 0);
    do_start();
    for (int i = 0; i < 15; i++) cycle();

    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      rst        = ($urandom_range(0, 499) == 0);
      u_if.start = ($urandom_range(0, 7) == 0);
      u_if.hold  = ($urandom_range(0, 4) == 0);
      u_if.st1   = ($urandom_range(0, 3) == 0) ? STATE_W'(GOAL) : STATE_W'($urandom_range(0, 15));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dqn_cu_param.md
# dqn_cu_param

Parametrised training control unit for the DQN datapath. It sequences the per-step controller phase, the step-within-episode counter and the episode counter. Episodes end on goal state or step timeout, and the unit halts cleanly after a configured number of episodes. It adds a start handshake, a hold (pause) input, a sticky done state and single-cycle event pulses. All datapath stages key off `controller`, `step` and `episode`.

## Interface
Parameters:
- `PHASES`, default 10: controller phases per step (≥2); `controller` runs 1..PHASES.
- `CTRL_W`, default 4: width of `controller`; 2^CTRL_W > PHASES.
- `STEP_W`, default 4: width of `step`.
- `MAX_STEP`, default 15: last step index of an episode (≤ 2^STEP_W−1).
- `EP_W`, default 12: width of `episode`.
- `MAX_EP`, default 4095: episodes to run before done (1..2^EP_W−1).
- `STATE_W`, default 4: width of `st1`.
- `GOAL_STATE`, default 9: terminal state code.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: level, sampled in IDLE only.
- `hold` input 1: freezes all counters and pulses while in RUN.
- `st1` input STATE_W: next-state from environment; sampled at step boundary.
- `controller` output CTRL_W: current phase; 0 when not running.
- `step` output STEP_W: step index in current episode.
- `episode` output EP_W: completed episode count.
- `step_tick` output 1: one-cycle pulse, a step boundary just occurred.
- `episode_end` output 1: one-cycle pulse, an episode just completed.
- `goal_hit` output 1: one-cycle pulse, the completed episode ended on GOAL_STATE.
- `busy` output 1: state == RUN.
- `done` output 1: state == DONE.

## Operation
- States: IDLE, RUN, DONE. The reset state is IDLE.
- Reset values: controller=0, step=0, episode=0, all pulses=0, busy=0, done=0.
- In IDLE, controller is held at 0. When `start`=1: go to RUN and set controller←1.
- In RUN with `hold`=1: nothing changes, and pulses are forced to 0.
- In RUN with `hold`=0:
  - If controller≠PHASES: controller←controller+1.
  - If controller==PHASES (a step boundary): controller←1 and step_tick←1.
- At a step boundary, the episode ends if (step==MAX_STEP) or (st1==GOAL_STATE). Then:
  - step←0, episode←episode+1, episode_end←1.
  - goal_hit←(st1==GOAL_STATE); the goal takes precedence in the cause even when step==MAX_STEP too.
- At a step boundary where the episode does not end: step←step+1.
- If an episode ends and episode==MAX_EP−1:
  - episode←MAX_EP, state←DONE, controller←0, step←0.
  - The episode_end and goal_hit pulses still fire on that edge.
- DONE is sticky. Counters freeze, `start` is ignored, and only `rst` leaves DONE.
- All arithmetic is unsigned. Neither step nor episode can wrap, because of MAX_STEP, MAX_EP and the DONE state.
- `rst` has priority over everything, including mid-step and mid-hold. All registers return to reset values on that edge.

## Timing
- All outputs are registered. Pulses are high for exactly one cycle: the cycle after the boundary edge, coincident with the updated counters.
- Start latency: with start sampled at edge E, controller=1 after E.
- Step period: PHASES unheld cycles. The first boundary is at edge E+PHASES.
- A timeout episode lasts (MAX_STEP+1)·PHASES unheld cycles.
- `hold` adds cycle-for-cycle delay. Holding across a boundary delays the boundary; it does not drop it.
- `st1` is sampled only on the boundary edge. Values at other cycles are don't-care.

## Configuration
- `DQN_CU_GOALCNT_EN` defined:
  - Adds output `goal_count` (EP_W wide, reset 0).
  - It increments on every edge that sets goal_hit, and freezes in DONE.
- Without the macro: the `goal_count` port and its register are absent, and all other behaviour is identical.

## Test plan
- Reset/idle: rst high 2 cycles, start=0 for 20 cycles -> controller=0, step=0, episode=0, busy=0, done=0 throughout.
- Timeout episode (defaults, st1=1): start at E -> step_tick at E+10, E+20, …; step reaches 15. Then at E+160: step=0, episode=1, episode_end=1, goal_hit=0.
- Goal episode: st1=9 held from step 3 -> at the boundary where step==3: step=0, episode=1, goal_hit=1. goal_count=1 if the macro is defined.
- Hold: assert hold for 7 cycles at controller=5 -> controller stays 5 and no pulses. The boundary is delayed 7 cycles, so step_tick occurs at E+17.
- Completion (MAX_EP=3, st1=9 from start) -> episode_end at E+10, E+20, E+30. After E+30: episode=3, done=1, busy=0, controller=0. Later start=1 leaves the outputs unchanged.
- Reset mid-run: rst during step 7, controller=4 -> next cycle all outputs are at reset values and the state is IDLE; start works normally afterwards.
